alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - ID/EX pipeline register directly upstream of ArithmeticLogicUnit: captures decoded ops, drives ALU A, B, ALUOp.
// - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB; inserts one bubble per load-use hazard.
// - Valid/ready handshake to decode and execute; synchronous flush; saturating stall counter for perf.
// PARAMETERS
// XLEN      32   datapath width (A, B, operands, PC, imm)
// REGW       5   register index width
// CNTW      16   stall counter width
// PORTS
// clk          in   1     single clock, rising edge
// rst          in   1     asynchronous, active-high reset
// dec_valid    in   1     decode presents an instruction
// dec_ready    out  1     stage accepts it this cycle
// dec_rs1_data in   XLEN  register-file read 1
// dec_rs2_data in   XLEN  register-file read 2
// dec_pc       in   XLEN  instruction PC
// dec_imm      in   XLEN  sign-extended immediate
// dec_rs1      in   REGW  source index 1
// dec_rs2      in   REGW  source index 2
// dec_rd       in   REGW  destination index
// dec_alu_op   in   4     ALUOp (alu_pkg encoding)
// dec_a_src    in   1     0: rs1, 1: PC
// dec_b_src    in   1     0: rs2, 1: imm
// dec_ru_wr    in   1     instruction writes rd
// flush        in   1     kill held instruction (branch redirect)
// exm_wr       in   1     EX/MEM writes register
// exm_is_load  in   1     EX/MEM is a load (data not yet available)
// exm_rd       in   REGW  EX/MEM destination
// exm_data     in   XLEN  EX/MEM ALU result
// wb_wr        in   1     MEM/WB writes register
// wb_rd        in   REGW  MEM/WB destination
// wb_data      in   XLEN  MEM/WB writeback value
// ex_valid     out  1     A/B/ALUOp valid for ALU
// ex_ready     in   1     execute consumes this cycle
// A            out  XLEN  ALU operand A
// B            out  XLEN  ALU operand B
// ALUOp        out  4     ALU operation
// ex_rd        out  REGW  destination forwarded down pipe
// ex_ru_wr     out  1     write-enable forwarded down pipe
// stall_cnt    out  CNTW  load-use bubbles since reset, saturating
// BEHAVIOUR
// - Reset: valid_q=0, all held fields 0, stall_cnt=0; ex_valid=0, A=B=0, ALUOp=4'b0000, ex_rd=0, ex_ru_wr=0.
// - Capture: dec_valid && dec_ready at posedge loads all dec_* fields; valid_q=1. Latency decode->ALU = 1 cycle.
// - Forwarding: combinational on held fields. rsX==0 never forwarded (value 0 from reg file).
//   exm_wr && exm_rd==rsX wins over wb_wr && wb_rd==rsX; else held reg-file data.
// - A = a_src ? pc_q : fwd(rs1); B = b_src ? imm_q : fwd(rs2). Only used sources checked for hazards.
// - load_use = valid_q && exm_is_load && exm_wr && exm_rd!=0 && exm_rd matches a used source.
// - ex_valid = valid_q && !load_use; dec_ready = !valid_q || (ex_ready && !load_use).
// - Held fields stable while ex_valid && !ex_ready (no drop, no duplicate).
// - Handoff: ex_ready && ex_valid && !dec_valid -> valid_q=0 next edge.
// - stall_cnt += 1 each cycle load_use=1; holds at all-ones.
// - flush: valid_q=0 next edge; beats same-cycle capture; dec_ready forced 0 that cycle.
// - rst asserted mid-operation: immediate clear, held instruction discarded.
// STRUCTURE
// - alu_pkg: ALUOp constants (ADD=4'b0000, SUB=4'b1000, XOR=4'b0100, MUL=4'b1110), a_src/b_src enums, XLEN default.
// - Sub-module fwd_mux: one source (index, reg data, exm/wb buses) -> forwarded value; instantiated for rs1, rs2.
// TESTING
// - Reset: rst=1 mid-capture -> ex_valid=0, A=B=0, stall_cnt=0 immediately.
// - No hazard: rs1=1, rs2=8, ADD -> next cycle A=1, B=8, ALUOp=0000; ALU gives 9.
// - Forward priority: rs1=x5, exm rd5=4, wb rd5=7, SUB, rs2=2 -> A=4, B=2.
//   Same case with exm_wr=0 -> A=7; rd=x0 -> no forward.
// - Load-use: exm_is_load, exm_rd=x3, held rs2=x3 (XOR) -> ex_valid=0 one cycle, stall_cnt=1.
//   dec_ready=0; load clears -> B=wb_data.
// - Backpressure/flush: ex_ready=0 three cycles with MUL A=4, B=2 -> outputs stable.
//   Then flush with dec_valid=1 -> ex_valid=0 next cycle, new instr not captured.
// - Immediate/PC: a_src=1, b_src=1, pc=0x100, imm=0xFFFFFFFC, ADD -> A=0x100, B=0xFFFFFFFC.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings and operand-source selectors for the issue stage.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_MUL = 4'b1110;

    typedef enum logic {
        A_RS1 = 1'b0,
        A_PC  = 1'b1
    } a_src_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_src_e;

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Forwarding mux for one source register: EX/MEM beats MEM/WB beats the
// register-file value. x0 is never forwarded.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exm_wr,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_wr,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            exm_hit
);

    logic nz;
    logic wb_hit;

    assign nz      = (rs != '0);
    assign exm_hit = nz && exm_wr && (exm_rd == rs);
    assign wb_hit  = nz && wb_wr && (wb_rd == rs);

    // Priority select of the freshest producer
    always_comb begin
        data = rf_data;
        if (exm_hit)
            data = exm_data;
        else if (wb_hit)
            data = wb_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: holds one decoded op, forwards from
// EX/MEM and MEM/WB, and holds the op in place for a load-use bubble.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [XLEN-1:0] dec_rs1_data,
    input  logic [XLEN-1:0] dec_rs2_data,
    input  logic [XLEN-1:0] dec_pc,
    input  logic [XLEN-1:0] dec_imm,
    input  logic [REGW-1:0] dec_rs1,
    input  logic [REGW-1:0] dec_rs2,
    input  logic [REGW-1:0] dec_rd,
    input  logic [3:0]      dec_alu_op,
    input  logic            dec_a_src,
    input  logic            dec_b_src,
    input  logic            dec_ru_wr,
    input  logic            flush,
    input  logic            exm_wr,
    input  logic            exm_is_load,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_wr,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALUOp,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_ru_wr,
    output logic [CNTW-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      alu_op;
        a_src_e          a_src;
        b_src_e          b_src;
        logic            ru_wr;
    } instr_t;

    instr_t          held_q;
    logic            valid_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            rs1_exm_hit, rs2_exm_hit;
    logic            use_rs1, use_rs2;
    logic            load_use;
    logic            capture;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs       (held_q.rs1),
        .rf_data  (held_q.rs1_data),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (rs1_fwd),
        .exm_hit  (rs1_exm_hit)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs       (held_q.rs2),
        .rf_data  (held_q.rs2_data),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (rs2_fwd),
        .exm_hit  (rs2_exm_hit)
    );

    // A source that is replaced by PC/imm cannot cause a hazard
    assign use_rs1  = (held_q.a_src == A_RS1);
    assign use_rs2  = (held_q.b_src == B_RS2);
    assign load_use = valid_q && exm_is_load &&
                      ((use_rs1 && rs1_exm_hit) || (use_rs2 && rs2_exm_hit));

    assign ex_valid  = valid_q && !load_use;
    assign dec_ready = !flush && (!valid_q || (ex_ready && !load_use));
    assign capture   = dec_valid && dec_ready;

    assign A        = use_rs1 ? rs1_fwd : held_q.pc;
    assign B        = use_rs2 ? rs2_fwd : held_q.imm;
    assign ALUOp    = held_q.alu_op;
    assign ex_rd    = held_q.rd;
    assign ex_ru_wr = held_q.ru_wr;

    // Held op: flush wins, then capture (which may replace a retiring op), then retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            held_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q         <= 1'b1;
            held_q.rs1_data <= dec_rs1_data;
            held_q.rs2_data <= dec_rs2_data;
            held_q.pc       <= dec_pc;
            held_q.imm      <= dec_imm;
            held_q.rs1      <= dec_rs1;
            held_q.rs2      <= dec_rs2;
            held_q.rd       <= dec_rd;
            held_q.alu_op   <= dec_alu_op;
            held_q.a_src    <= a_src_e'(dec_a_src);
            held_q.b_src    <= b_src_e'(dec_b_src);
            held_q.ru_wr    <= dec_ru_wr;
        end else if (ex_valid && ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Saturating count of load-use bubble cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (load_use && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios, then randomized traffic
// checked by a scoreboard monitor against a one-entry reference model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_rs1_data, dec_rs2_data, dec_pc, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [3:0]  dec_alu_op;
    logic        dec_a_src, dec_b_src, dec_ru_wr;
    logic        flush;
    logic        exm_wr, exm_is_load;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        wb_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] A, B;
    logic [3:0]  ALUOp;
    logic [4:0]  ex_rd;
    logic        ex_ru_wr;
    logic [15:0] stall_cnt;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
        .dec_pc(dec_pc), .dec_imm(dec_imm),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_alu_op(dec_alu_op), .dec_a_src(dec_a_src), .dec_b_src(dec_b_src),
        .dec_ru_wr(dec_ru_wr), .flush(flush),
        .exm_wr(exm_wr), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .ex_rd(ex_rd), .ex_ru_wr(ex_ru_wr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, pc, imm;
        logic [3:0]  op;
        logic        a_src, b_src, ru_wr;
    } ins_t;

    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    bit   m_ready = 1'b0;
    int   m_stall = 0;
    ins_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        exm_wr = 0; exm_is_load = 0; exm_rd = 0; exm_data = 0;
        wb_wr = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic drive(input ins_t i);
        dec_rs1 = i.rs1; dec_rs2 = i.rs2; dec_rd = i.rd;
        dec_rs1_data = i.d1; dec_rs2_data = i.d2; dec_pc = i.pc; dec_imm = i.imm;
        dec_alu_op = i.op; dec_a_src = i.a_src; dec_b_src = i.b_src; dec_ru_wr = i.ru_wr;
    endtask

    function automatic ins_t mk(input logic [4:0] rs1, input logic [31:0] d1,
                                input logic [4:0] rs2, input logic [31:0] d2,
                                input logic [3:0] op, input logic [4:0] rd);
        ins_t i;
        i.rs1 = rs1; i.d1 = d1; i.rs2 = rs2; i.d2 = d2; i.op = op; i.rd = rd;
        i.pc = 32'h0; i.imm = 32'h0; i.a_src = 0; i.b_src = 0; i.ru_wr = 1;
        return i;
    endfunction

    // One-cycle capture into an empty stage
    task automatic issue(input ins_t i);
        drive(i);
        dec_valid = 1;
        tick();
        dec_valid = 0;
    endtask

    task automatic drain();
        ex_ready = 1;
        tick();
        ex_ready = 0;
    endtask

    // Register value as the ALU should see it under the forwarding rules
    function automatic logic [31:0] see(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (exm_wr && exm_rd == r) return exm_data;
        if (wb_wr && wb_rd == r) return wb_data;
        return rf;
    endfunction

    // Scoreboard monitor: the queue holds at most the one op the stage owns
    always @(negedge clk) begin
        if (mon_on) begin
            bit          have, lu, ev;
            ins_t        h;
            logic [31:0] ea, eb;
            have = (sb.size() > 0);
            lu = 0;
            if (have) begin
                h = sb[0];
                lu = exm_is_load && exm_wr && exm_rd != 0 &&
                     ((!h.a_src && exm_rd == h.rs1) || (!h.b_src && exm_rd == h.rs2));
            end
            ev = have && !lu;
            m_ready = !flush && (!have || (ex_ready && !lu));
            chk("rnd_ex_valid", {31'b0, ex_valid}, {31'b0, ev});
            chk("rnd_dec_ready", {31'b0, dec_ready}, {31'b0, m_ready});
            chk("rnd_stall_cnt", {16'b0, stall_cnt}, m_stall);
            if (lu && m_stall < 65535) m_stall++;
            if (ev && ex_valid) begin
                ea = h.a_src ? h.pc : see(h.rs1, h.d1);
                eb = h.b_src ? h.imm : see(h.rs2, h.d2);
                chk("rnd_A", A, ea);
                chk("rnd_B", B, eb);
                chk("rnd_ALUOp", {28'b0, ALUOp}, {28'b0, h.op});
                chk("rnd_ex_rd", {27'b0, ex_rd}, {27'b0, h.rd});
                chk("rnd_ex_ru_wr", {31'b0, ex_ru_wr}, {31'b0, h.ru_wr});
            end
            if (flush) sb.delete();
            else if (ev && ex_ready) void'(sb.pop_front());
        end
    end

    initial begin
        ins_t i;
        logic [3:0] ops [4];
        ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_XOR; ops[3] = ALU_MUL;

        rst = 1; dec_valid = 0; ex_ready = 0; flush = 0;
        drive(mk(0, 0, 0, 0, 0, 0));
        idle_bus();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_ALUOp", {28'b0, ALUOp}, 0);
        chk("rst_stall", {16'b0, stall_cnt}, 0);
        chk("rst_dec_ready", {31'b0, dec_ready}, 1);
        rst = 0;
        tick();

        // No hazard: x1=1 + x8=8
        issue(mk(1, 1, 8, 8, ALU_ADD, 4));
        chk("add_valid", {31'b0, ex_valid}, 1);
        chk("add_A", A, 1);
        chk("add_B", B, 8);
        chk("add_op", {28'b0, ALUOp}, {28'b0, ALU_ADD});
        chk("add_rd", {27'b0, ex_rd}, 4);
        chk("add_sum", A + B, 9);
        drain();
        chk("add_retired", {31'b0, ex_valid}, 0);

        // Forwarding priority on rs1=x5
        issue(mk(5, 99, 2, 2, ALU_SUB, 7));
        exm_wr = 1; exm_rd = 5; exm_data = 4;
        wb_wr = 1; wb_rd = 5; wb_data = 7;
        #1;
        chk("fwd_exm_A", A, 4);
        chk("fwd_exm_B", B, 2);
        chk("fwd_op", {28'b0, ALUOp}, {28'b0, ALU_SUB});
        exm_wr = 0;
        #1;
        chk("fwd_wb_A", A, 7);
        exm_wr = 1; exm_rd = 0; wb_rd = 0;
        #1;
        chk("fwd_miss_A", A, 99);
        drain();
        issue(mk(0, 0, 2, 2, ALU_SUB, 7));
        chk("fwd_x0_A", A, 0);
        drain();
        idle_bus();

        // Load-use on rs2=x3
        issue(mk(1, 10, 3, 50, ALU_XOR, 6));
        exm_is_load = 1; exm_wr = 1; exm_rd = 3; exm_data = 32'hdead;
        ex_ready = 1;
        drive(mk(1, 200, 2, 2, ALU_ADD, 9));
        dec_valid = 1;
        #1;
        chk("lu_ex_valid", {31'b0, ex_valid}, 0);
        chk("lu_dec_ready", {31'b0, dec_ready}, 0);
        tick();
        idle_bus();
        wb_wr = 1; wb_rd = 3; wb_data = 123;
        dec_valid = 0; ex_ready = 0;
        #1;
        chk("lu_stall_cnt", {16'b0, stall_cnt}, 1);
        chk("lu_resume_valid", {31'b0, ex_valid}, 1);
        chk("lu_resume_A", A, 10);
        chk("lu_resume_B", B, 123);
        chk("lu_resume_op", {28'b0, ALUOp}, {28'b0, ALU_XOR});
        drain();
        idle_bus();

        // Backpressure, then flush against a same-cycle capture
        issue(mk(1, 4, 2, 2, ALU_MUL, 5));
        drive(mk(1, 55, 2, 66, ALU_ADD, 8));
        dec_valid = 1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {31'b0, ex_valid}, 1);
            chk("bp_A", A, 4);
            chk("bp_B", B, 2);
            chk("bp_op", {28'b0, ALUOp}, {28'b0, ALU_MUL});
            chk("bp_dec_ready", {31'b0, dec_ready}, 0);
            tick();
        end
        flush = 1;
        #1;
        chk("fl_dec_ready", {31'b0, dec_ready}, 0);
        tick();
        flush = 0; dec_valid = 0;
        chk("fl_valid", {31'b0, ex_valid}, 0);
        tick();
        chk("fl_no_capture", {31'b0, ex_valid}, 0);

        // PC/imm operands; a load targeting the unused sources must not stall
        exm_is_load = 1; exm_wr = 1; exm_rd = 1;
        i = mk(1, 5, 1, 6, ALU_ADD, 2);
        i.a_src = 1; i.b_src = 1; i.pc = 32'h100; i.imm = 32'hFFFF_FFFC;
        issue(i);
        chk("imm_valid", {31'b0, ex_valid}, 1);
        chk("imm_A", A, 32'h100);
        chk("imm_B", B, 32'hFFFF_FFFC);
        chk("imm_stall_hold", {16'b0, stall_cnt}, 1);
        drain();
        idle_bus();

        // Asynchronous reset while holding an op and offering another
        issue(mk(2, 9, 3, 11, ALU_SUB, 4));
        drive(mk(1, 1, 1, 1, ALU_ADD, 1));
        dec_valid = 1;
        #2 rst = 1;
        #1;
        chk("arst_valid", {31'b0, ex_valid}, 0);
        chk("arst_A", A, 0);
        chk("arst_B", B, 0);
        chk("arst_stall", {16'b0, stall_cnt}, 0);
        tick();
        rst = 0; dec_valid = 0;

        // Randomized traffic under the scoreboard
        m_stall = 0;
        sb.delete();
        mon_on = 1;
        for (int n = 0; n < 600; n++) begin
            i.rs1 = 5'($urandom_range(0, 3));
            i.rs2 = 5'($urandom_range(0, 3));
            i.rd = 5'($urandom_range(0, 31));
            i.d1 = $urandom; i.d2 = $urandom; i.pc = $urandom; i.imm = $urandom;
            i.op = ops[$urandom_range(0, 3)];
            i.a_src = ($urandom_range(0, 3) == 0);
            i.b_src = ($urandom_range(0, 3) == 0);
            i.ru_wr = 1'($urandom);
            drive(i);
            dec_valid = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 15) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            exm_wr = 1'($urandom);
            exm_is_load = ($urandom_range(0, 3) == 0);
            exm_rd = 5'($urandom_range(0, 3));
            exm_data = $urandom;
            wb_wr = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            @(posedge clk);
            if (dec_valid && m_ready && !flush) sb.push_back(i);
            #1;
        end
        mon_on = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
